ddr_cmd_decoder: RTL
====================

DDR_CMD_DECODER -- requirements
Module: ddr_cmd_decoder

Interface
Parameters, one per line: name, default, meaning.
REQ-001 BANKGROUPS, 4, number of bank groups.
REQ-002 BANKSPERGROUP, 4, banks per group; BANKS = BANKGROUPS*BANKSPERGROUP (localparam).
REQ-003 ROWS, 131072, rows per bank; row width $clog2(ROWS).
REQ-004 COLS, 1024, columns per row; column width $clog2(COLS).

Ports, one per line: name, direction, width, meaning. Clock and reset come first.
REQ-005 clk, in, 1, single clock; all state updates on its rising edge.
REQ-006 rst, in, 1, reset; asynchronous and active-high.
REQ-007 cke, cs_n, act_n, ras_n, cas_n, we_n: in, 1 each, DDR4 command pins; ras_n/cas_n/we_n are A16/A15/A14.
REQ-008 bg, in, $clog2(BANKGROUPS), bank group; ba, in, $clog2(BANKSPERGROUP), bank.
REQ-009 addr, in, 18, address pins A17..A0.
REQ-010 ACT, RD, RDA, WR, WRA, PR, PRA, REF: out, BANKS each, per-bank one-cycle command strobes.
REQ-011 SRF, PD, PDX, CKEH, CKEL: out, BANKS each, power strobes, broadcast to all banks.
REQ-012 row, out, $clog2(ROWS), row address; column, out, $clog2(COLS), column address.
REQ-013 bank_open, out, BANKS, open-row status per bank.
REQ-014 illegal, out, 1, one-cycle pulse when a command is rejected.

Function
REQ-015 Inputs sampled each clk; outputs registered; latency exactly 1 cycle from command cycle to strobe.
REQ-016 Bank index = bg*BANKSPERGROUP + ba.
REQ-017 Deselect is cs_n=1; NOP is cs_n=0, act_n=1, ras_n/cas_n/we_n=HHH; both produce no strobe.
REQ-018 ACT is cs_n=0 and act_n=0; row is addr[$clog2(ROWS)-1:0]; sets bank_open[bank].
REQ-019 With act_n=1, ras_n/cas_n/we_n decode as: LLH=REF, LHL=PR (addr[10]=1 gives PRA), HLH=RD (addr[10]=1 gives RDA), HLL=WR (addr[10]=1 gives WRA); column is addr[$clog2(COLS)-1:0].
REQ-020 MRS (LLL) and ZQC (HHL) are accepted, produce no strobe and are not flagged illegal.
REQ-021 PR clears bank_open[bank]; PRA asserts PRA on all BANKS bits and clears all bank_open bits.
REQ-022 RDA/WRA strobe and clear bank_open[bank] in the same update.
REQ-023 Illegal cases, each suppressing all strobes and pulsing illegal for 1 cycle: ACT to an open bank; RD/RDA/WR/WRA to a closed bank; REF while any bank is open; any command issued while pstate!=NORMAL.
REQ-024 PR to a closed bank is legal; the strobe is still issued.
REQ-025 row and column hold their last value when no ACT/RD/WR is issued.
REQ-026 Power FSM pstate has states NORMAL, PWRDN, SELFREF. cke_q is the registered cke.
REQ-027 Transition NORMAL->SELFREF: REF decoded with cke_q=1 and cke=0; emits SRF and CKEL; REF strobe suppressed.
REQ-028 Transition NORMAL->PWRDN: cke_q=1, cke=0 and no REF; emits PD and CKEL.
REQ-029 Transition PWRDN->NORMAL: cke 0->1; emits PDX and CKEH.
REQ-030 Transition SELFREF->NORMAL: cke 0->1; emits CKEH only.
REQ-031 While pstate!=NORMAL and cke=0, command pins are ignored and illegal stays 0.
REQ-032 Every strobe output is one-hot or zero per command, except PRA and the power strobes, which are all-ones or zero.

Reset
REQ-033 While rst=1: all strobes=0, illegal=0, bank_open=0, row=0, column=0, pstate=NORMAL, cke_q=1.
REQ-034 Reset asserted mid-command discards that command; the first strobe after reset release appears one cycle after the first valid command.

Structure
REQ-035 The command encoding enum (NOP, DES, ACT, RD, RDA, WR, WRA, PR, PRA, REF, MRS, ZQC) and the pstate enum belong in the shared package ddr_pkg.
REQ-036 Sub-module bank_state_tracker holds bank_open and produces the legality check; the decode and the power FSM stay in the top level.

Verification
REQ-037 ACT bg=1, ba=2, addr=0x1ABCD, then RD bg=1, ba=2, addr=0x005 -> ACT[6]=1 at t+1 with row=0x1ABCD; RD[6]=1 at t+2 with column=5; illegal=0.
REQ-038 RD to bank 3 with bank_open=0 -> illegal=1 for 1 cycle; RD=0; bank_open unchanged.
REQ-039 Open banks 0 and 5, then PR addr[10]=1 -> PRA=all ones; bank_open=0; a following REF is accepted and REF strobe is broadcast.
REQ-040 REF with cke 1->0 -> SRF=all ones and CKEL=all ones; REF=0; an ACT while cke=0 is ignored; cke 0->1 -> CKEH=all ones; PDX=0.
REQ-041 NOP with cke 1->0, then cke 0->1 -> PD then PDX, each with the matching CKEL/CKEH.
REQ-042 Assert rst while bank 2 is open and WR is on the pins -> no WR strobe; bank_open=0; outputs zero the same cycle (asynchronous).

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared DDR4 command and power-state encodings plus the pin-level command decode.
package ddr_pkg;

  typedef enum logic [3:0] {
    CmdNop, CmdDes, CmdAct, CmdRd, CmdRda, CmdWr, CmdWra,
    CmdPr, CmdPra, CmdRef, CmdMrs, CmdZqc
  } cmd_e;

  typedef enum logic [1:0] {PsNormal, PsPwrdn, PsSelfref} pstate_e;

  // ras_n/cas_n/we_n are only meaningful as command bits when act_n is high.
  function automatic cmd_e decode_cmd(input logic cs_n, input logic act_n, input logic ras_n,
                                      input logic cas_n, input logic we_n, input logic a10);
    cmd_e c;
    c = CmdNop;
    if (cs_n) begin
      c = CmdDes;
    end else if (!act_n) begin
      c = CmdAct;
    end else begin
      case ({ras_n, cas_n, we_n})
        3'b001:  c = CmdRef;
        3'b010:  c = a10 ? CmdPra : CmdPr;
        3'b101:  c = a10 ? CmdRda : CmdRd;
        3'b100:  c = a10 ? CmdWra : CmdWr;
        3'b000:  c = CmdMrs;
        3'b110:  c = CmdZqc;
        default: c = CmdNop;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/bank_state_tracker.sv
// Open-row bookkeeping per bank and the bank-state legality check for a decoded command.
module bank_state_tracker
  import ddr_pkg::*;
#(
  parameter int unsigned BANKS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  cmd_e                     cmd,
  input  logic [$clog2(BANKS)-1:0] bank,
  input  logic                     update,
  output logic [BANKS-1:0]         bank_open,
  output logic                     legal
);

  logic [BANKS-1:0] open_q, open_d;
  logic             is_open;

  assign is_open   = open_q[bank];
  assign bank_open = open_q;

  always_comb begin
    case (cmd)
      CmdAct:                      legal = !is_open;
      CmdRd, CmdRda, CmdWr, CmdWra: legal = is_open;
      CmdRef:                      legal = ~|open_q;
      default:                     legal = 1'b1;
    endcase
  end

  always_comb begin
    open_d = open_q;
    if (update) begin
      case (cmd)
        CmdAct:                open_d[bank] = 1'b1;
        CmdPr, CmdRda, CmdWra: open_d[bank] = 1'b0;
        CmdPra:                open_d = '0;
        default:               ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      open_q <= '0;
    end else begin
      open_q <= open_d;
    end
  end

endmodule

// File: rtl/ddr_cmd_decoder.sv
// DDR4 command decoder: registered per-bank command strobes, open-row legality and CKE power FSM.
module ddr_cmd_decoder
  import ddr_pkg::*;
#(
  parameter int unsigned BANKGROUPS    = 4,
  parameter int unsigned BANKSPERGROUP = 4,
  parameter int unsigned ROWS          = 131072,
  parameter int unsigned COLS          = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cke,
  input  logic                             cs_n,
  input  logic                             act_n,
  input  logic                             ras_n,
  input  logic                             cas_n,
  input  logic                             we_n,
  input  logic [$clog2(BANKGROUPS)-1:0]    bg,
  input  logic [$clog2(BANKSPERGROUP)-1:0] ba,
  input  logic [17:0]                      addr,
  output logic [BANKGROUPS*BANKSPERGROUP-1:0] ACT,
  output logic [BANKGROUPS*BANKSPERGROUP-1:0] RD,
  output logic [BANKGROUPS*BANKSPERGROUP-1:0] RDA,
  output logic [BANKGROUPS*BANKSPERGROUP-1:0] WR,
  output logic [BANKGROUPS*BANKSPERGROUP-1:0] WRA,
  output logic [BANKGROUPS*BANKSPERGROUP-1:0] PR,
  output logic [BANKGROUPS*BANKSPERGROUP-1:0] PRA,
  output logic [BANKGROUPS*BANKSPERGROUP-1:0] REF,
  output logic [BANKGROUPS*BANKSPERGROUP-1:0] SRF,
  output logic [BANKGROUPS*BANKSPERGROUP-1:0] PD,
  output logic [BANKGROUPS*BANKSPERGROUP-1:0] PDX,
  output logic [BANKGROUPS*BANKSPERGROUP-1:0] CKEH,
  output logic [BANKGROUPS*BANKSPERGROUP-1:0] CKEL,
  output logic [$clog2(ROWS)-1:0]          row,
  output logic [$clog2(COLS)-1:0]          column,
  output logic [BANKGROUPS*BANKSPERGROUP-1:0] bank_open,
  output logic                             illegal
);

  localparam int unsigned BANKS = BANKGROUPS * BANKSPERGROUP;
  localparam int unsigned BankW = $clog2(BANKS);
  localparam int unsigned RowW  = $clog2(ROWS);
  localparam int unsigned ColW  = $clog2(COLS);

  logic [BANKS-1:0] act_q, rd_q, rda_q, wr_q, wra_q, pr_q, pra_q, ref_q;
  logic [BANKS-1:0] act_d, rd_d, rda_d, wr_d, wra_d, pr_d, pra_d, ref_d;
  logic [BANKS-1:0] srf_q, pd_q, pdx_q, ckeh_q, ckel_q;
  logic [BANKS-1:0] srf_d, pd_d, pdx_d, ckeh_d, ckel_d;
  logic [RowW-1:0]  row_q, row_d;
  logic [ColW-1:0]  col_q, col_d;
  logic             illegal_q, illegal_d;
  logic             cke_q;
  pstate_e          pstate_q, pstate_d;

  cmd_e             cmd;
  logic [BankW-1:0] bank;
  logic             legal, update, is_cmd;
  logic             unused_addr;

  assign cmd         = decode_cmd(cs_n, act_n, ras_n, cas_n, we_n, addr[10]);
  assign bank        = BankW'(bg) * BankW'(BANKSPERGROUP) + BankW'(ba);
  assign is_cmd      = (cmd != CmdNop) && (cmd != CmdDes);
  assign unused_addr = ^addr;

  bank_state_tracker #(
    .BANKS(BANKS)
  ) u_tracker (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd),
    .bank     (bank),
    .update   (update),
    .bank_open(bank_open),
    .legal    (legal)
  );

  always_comb begin
    {act_d, rd_d, rda_d, wr_d, wra_d, pr_d, pra_d, ref_d} = '0;
    {srf_d, pd_d, pdx_d, ckeh_d, ckel_d} = '0;
    illegal_d = 1'b0;
    update    = 1'b0;
    pstate_d  = pstate_q;
    row_d     = row_q;
    col_d     = col_q;
    case (pstate_q)
      PsNormal: begin
        if (cke_q && !cke) begin
          // Falling CKE: REF turns into self-refresh entry, anything else is power-down entry.
          if (cmd == CmdRef && legal) begin
            pstate_d = PsSelfref;
            srf_d    = '1;
            ckel_d   = '1;
          end else if (cmd == CmdRef) begin
            illegal_d = 1'b1;
          end else begin
            pstate_d = PsPwrdn;
            pd_d     = '1;
            ckel_d   = '1;
          end
        end else if (!legal) begin
          illegal_d = 1'b1;
        end else begin
          update = 1'b1;
          case (cmd)
            CmdAct: begin act_d[bank] = 1'b1; row_d = addr[RowW-1:0]; end
            CmdRd:  begin rd_d[bank]  = 1'b1; col_d = addr[ColW-1:0]; end
            CmdRda: begin rda_d[bank] = 1'b1; col_d = addr[ColW-1:0]; end
            CmdWr:  begin wr_d[bank]  = 1'b1; col_d = addr[ColW-1:0]; end
            CmdWra: begin wra_d[bank] = 1'b1; col_d = addr[ColW-1:0]; end
            CmdPr:  pr_d[bank] = 1'b1;
            CmdPra: pra_d = '1;
            CmdRef: ref_d = '1;
            default: ;
          endcase
        end
      end
      default: begin
        // Low-power states: pins are ignored until CKE rises; a real command on that edge is rejected.
        if (cke) begin
          pstate_d  = PsNormal;
          ckeh_d    = '1;
          pdx_d     = (pstate_q == PsPwrdn) ? '1 : '0;
          illegal_d = is_cmd;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {act_q, rd_q, rda_q, wr_q, wra_q, pr_q, pra_q, ref_q} <= '0;
      {srf_q, pd_q, pdx_q, ckeh_q, ckel_q} <= '0;
      row_q     <= '0;
      col_q     <= '0;
      illegal_q <= 1'b0;
      cke_q     <= 1'b1;
      pstate_q  <= PsNormal;
    end else begin
      {act_q, rd_q, rda_q, wr_q, wra_q, pr_q, pra_q, ref_q} <=
          {act_d, rd_d, rda_d, wr_d, wra_d, pr_d, pra_d, ref_d};
      {srf_q, pd_q, pdx_q, ckeh_q, ckel_q} <= {srf_d, pd_d, pdx_d, ckeh_d, ckel_d};
      row_q     <= row_d;
      col_q     <= col_d;
      illegal_q <= illegal_d;
      cke_q     <= cke;
      pstate_q  <= pstate_d;
    end
  end

  assign {ACT, RD, RDA, WR, WRA, PR, PRA, REF} = {act_q, rd_q, rda_q, wr_q, wra_q, pr_q, pra_q, ref_q};
  assign {SRF, PD, PDX, CKEH, CKEL} = {srf_q, pd_q, pdx_q, ckeh_q, ckel_q};
  assign row     = row_q;
  assign column  = col_q;
  assign illegal = illegal_q;

endmodule
